id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter N, default 32, data/register width; SHALL support N >= 32.
REQ-002 Parameter NREG, default 32, register count; SHALL be a power of two, at most 32.
REQ-003 Parameter CW, default 16, stall-counter width.
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  instruction word present.
REQ-007 in_ready  out  1  stage accepts an instruction this cycle.
REQ-008 instruction  in  32  fields: op[31:29], rw[28:24], ra[23:19], rb[18:14], func[1:0].
REQ-009 rb_selector  in  1  0: port B addresses rb; 1: port B addresses rw.
REQ-010 ext_selector  in  2  immediate mode, defined in REQ-020.
REQ-011 we, wr_addr, wd  in  1, 5, N  write-back port.
REQ-012 ex_load_valid, ex_load_rd  in  1, 5  load in flight in EX and its destination.
REQ-013 out_valid  out  1  ID/EX register holds a valid instruction.
REQ-014 out_ready  in  1  downstream accepts the ID/EX contents.
REQ-015 op, func, ra, rb, rw, rda, rdb, extended  out  3, 2, 5, 5, 5, N, N, N  registered decode results.
REQ-016 stall_count  out  CW  number of load-use stall cycles.

Function
REQ-017 The register file SHALL hold NREG x N bits, addressed by the low log2(NREG) bits of each address; register 0 SHALL read 0 and ignore writes.
REQ-018 Write-back SHALL be committed on the clock edge when we=1.
REQ-019 Same-cycle bypass: a read whose address equals wr_addr while we=1 SHALL return wd, except for address 0.
REQ-020 extended SHALL be formed per ext_selector: 00 zero-extend instr[13:0]; 01 sign-extend instr[13:0]; 10 zero-extend instr[28:0]; 11 sign-extend instr[28:0].
REQ-021 Port B address src_b SHALL be rb when rb_selector=0, and rw otherwise.
REQ-022 Hazard condition: hazard=1 when in_valid, ex_load_valid, ex_load_rd!=0, and ex_load_rd equals ra or src_b.
REQ-023 in_ready SHALL equal (!out_valid | out_ready) & !hazard.
REQ-024 On in_valid & in_ready, the ID/EX register SHALL load all decode outputs and set out_valid=1; latency is one cycle.
REQ-025 When out_valid & out_ready and no new instruction is accepted, out_valid SHALL clear.
REQ-026 When out_valid=1 & out_ready=0, all outputs SHALL hold stable.
REQ-027 When hazard=1 and downstream is free (!out_valid | out_ready), out_valid SHALL be 0 next cycle (bubble); the instruction is not consumed.
REQ-028 stall_count SHALL increment by 1 in each hazard cycle and saturate at all-ones.
REQ-029 A simultaneous write-back to a register being decoded SHALL deliver the new value into rda/rdb.

Reset
REQ-030 While reset=0 at a clock edge: out_valid=0, stall_count=0, and op, func, ra, rb, rw, rda, rdb, extended all 0; all registers 1..NREG-1 SHALL clear to 0.
REQ-031 in_ready SHALL be 0 while reset=0.
REQ-032 Reset asserted mid-handshake SHALL discard the held instruction; the first accept SHALL occur on the first edge after reset returns to 1.

Verification
REQ-033 Scenario 1: write r5=0x1234 then decode op=3 rw=2 ra=5 rb=0 -> next cycle out_valid=1, rda=0x1234, rdb=0, rw=2.
REQ-034 Scenario 2: decode ra=7 with we=1, wr_addr=7, wd=0xABCD in the same cycle -> rda=0xABCD.
REQ-035 Scenario 3: ext_selector=01, instr[13:0]=0x2000 -> extended=0xFFFFE000 (N=32); ext_selector=00 -> 0x00002000.
REQ-036 Scenario 4: ex_load_valid=1, ex_load_rd=4, ra=4 for 2 cycles -> in_ready=0, two bubbles, stall_count=2, then accept once ex_load_valid=0.
REQ-037 Scenario 5: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; ex_load_rd=0 with ra=0 -> no stall.
REQ-038 Scenario 6: reset=0 while out_valid=1 -> next edge out_valid=0, all outputs 0, r5 reads 0 afterwards.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage. It holds the register file with a same-cycle write-back
// bypass, generates the immediate, detects load-use hazards against EX, and drives a
// registered ID/EX output with a valid/ready handshake.
module id_stage_pipe #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned CW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instruction,
    input  logic          rb_selector,
    input  logic [1:0]    ext_selector,
    input  logic          we,
    input  logic [4:0]    wr_addr,
    input  logic [N-1:0]  wd,
    input  logic          ex_load_valid,
    input  logic [4:0]    ex_load_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    op,
    output logic [1:0]    func,
    output logic [4:0]    ra,
    output logic [4:0]    rb,
    output logic [4:0]    rw,
    output logic [N-1:0]  rda,
    output logic [N-1:0]  rdb,
    output logic [N-1:0]  extended,
    output logic [CW-1:0] stall_count
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [N-1:0] rf_q [NREG];

    logic [2:0] dec_op;
    logic [1:0] dec_func;
    logic [4:0] dec_ra, dec_rb, dec_rw, src_b;
    logic [AW-1:0] ra_idx, rb_idx, wr_idx;
    logic [N-1:0] rda_raw, rdb_raw, ext_raw;
    logic hazard, accept;

    logic          valid_q, valid_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    func_q, func_d;
    logic [4:0]    ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
    logic [N-1:0]  rda_q, rda_d, rdb_q, rdb_d, ext_q, ext_d;
    logic [CW-1:0] stall_q, stall_d;

    assign dec_op   = instruction[31:29];
    assign dec_rw   = instruction[28:24];
    assign dec_ra   = instruction[23:19];
    assign dec_rb   = instruction[18:14];
    assign dec_func = instruction[1:0];
    assign src_b    = rb_selector ? dec_rw : dec_rb;

    assign ra_idx = dec_ra[AW-1:0];
    assign rb_idx = src_b[AW-1:0];
    assign wr_idx = wr_addr[AW-1:0];

    // Only a load whose result is not yet available can stall; r0 never carries data.
    assign hazard = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((ex_load_rd == dec_ra) || (ex_load_rd == src_b));
    assign in_ready = reset && (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Register file: synchronous clear on reset, write-back on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we && (wr_idx != '0)) begin
            rf_q[wr_idx] <= wd;
        end
    end

    // Port A read with write-back bypass; r0 is hard-wired to zero.
    always_comb begin
        rda_raw = rf_q[ra_idx];
        if (ra_idx == '0) begin
            rda_raw = '0;
        end else if (we && (wr_idx == ra_idx)) begin
            rda_raw = wd;
        end
    end

    // Port B read with write-back bypass; r0 is hard-wired to zero.
    always_comb begin
        rdb_raw = rf_q[rb_idx];
        if (rb_idx == '0) begin
            rdb_raw = '0;
        end else if (we && (wr_idx == rb_idx)) begin
            rdb_raw = wd;
        end
    end

    // Immediate generation: 14-bit or 29-bit field, zero- or sign-extended.
    always_comb begin
        ext_raw = '0;
        unique case (ext_selector)
            2'b00: ext_raw = {{(N-14){1'b0}}, instruction[13:0]};
            2'b01: ext_raw = {{(N-14){instruction[13]}}, instruction[13:0]};
            2'b10: ext_raw = {{(N-29){1'b0}}, instruction[28:0]};
            2'b11: ext_raw = {{(N-29){instruction[28]}}, instruction[28:0]};
            default: ext_raw = '0;
        endcase
    end

    // ID/EX next state: load on accept, drop valid once consumed, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        func_d  = func_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rw_d    = rw_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        ext_d   = ext_q;
        stall_d = stall_q;
        if (accept) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            func_d  = dec_func;
            ra_d    = dec_ra;
            rb_d    = dec_rb;
            rw_d    = dec_rw;
            rda_d   = rda_raw;
            rdb_d   = rdb_raw;
            ext_d   = ext_raw;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (hazard && (stall_q != '1)) begin
            stall_d = stall_q + CW'(1);
        end
    end

    // ID/EX and stall counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            func_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rw_q    <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            ext_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            func_q  <= func_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rw_q    <= rw_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            ext_q   <= ext_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign op          = op_q;
    assign func        = func_q;
    assign ra          = ra_q;
    assign rb          = rb_q;
    assign rw          = rw_q;
    assign rda         = rda_q;
    assign rdb         = rdb_q;
    assign extended    = ext_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios then random traffic, with a queue-based
// scoreboard fed at issue time and drained by an independent output monitor.
module tb_id_stage_pipe;

    localparam int N  = 32;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic          rb_selector;
    logic [1:0]    ext_selector;
    logic          we;
    logic [4:0]    wr_addr;
    logic [N-1:0]  wd;
    logic          ex_load_valid;
    logic [4:0]    ex_load_rd;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    op;
    logic [1:0]    func;
    logic [4:0]    ra, rb, rw;
    logic [N-1:0]  rda, rdb, extended;
    logic [CW-1:0] stall_count;

    id_stage_pipe #(.N(N), .NREG(32), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .rb_selector   (rb_selector),
        .ext_selector  (ext_selector),
        .we            (we),
        .wr_addr       (wr_addr),
        .wd            (wd),
        .ex_load_valid (ex_load_valid),
        .ex_load_rd    (ex_load_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op            (op),
        .func          (func),
        .ra            (ra),
        .rb            (rb),
        .rw            (rw),
        .rda           (rda),
        .rdb           (rdb),
        .extended      (extended),
        .stall_count   (stall_count)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  func;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic [31:0] ext;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_rf [32];
    logic        model_ov;
    int unsigned model_stall;
    int          n_cmp;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] o, input logic [4:0] w,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [13:0] lo);
        return {o, w, a, b, lo};
    endfunction

    // Immediate reference: plain masking and two's-complement offset arithmetic.
    function automatic logic [31:0] ext_model(input logic [31:0] ins, input logic [1:0] sel);
        logic [31:0] lo;
        case (sel)
            2'd0: return ins & 32'h0000_3FFF;
            2'd1: begin
                lo = ins & 32'h0000_3FFF;
                return (lo >= 32'h2000) ? lo - 32'h4000 : lo;
            end
            2'd2: return ins & 32'h1FFF_FFFF;
            default: begin
                lo = ins & 32'h1FFF_FFFF;
                return (lo >= 32'h1000_0000) ? lo - 32'h2000_0000 : lo;
            end
        endcase
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && wr_addr == a) return wd;
        return ref_rf[a];
    endfunction

    // One clock of stimulus: predict, check cycle-level outputs, advance the model.
    task automatic cycle();
        logic [4:0] a, sb;
        logic hz, rdy, acc;
        exp_t e;
        a   = instruction[23:19];
        sb  = rb_selector ? instruction[28:24] : instruction[18:14];
        hz  = in_valid && ex_load_valid && ex_load_rd != 5'd0 &&
              (ex_load_rd == a || ex_load_rd == sb);
        rdy = reset && (!model_ov || out_ready) && !hz;
        acc = in_valid && rdy;
        if (acc) begin
            e.op   = instruction[31:29];
            e.func = instruction[1:0];
            e.ra   = a;
            e.rb   = instruction[18:14];
            e.rw   = instruction[28:24];
            e.rda  = rd_model(a);
            e.rdb  = rd_model(sb);
            e.ext  = ext_model(instruction, ext_selector);
            exp_q.push_back(e);
        end
        #1;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, model_ov);
        check("stall_count", stall_count, model_stall);
        if (!reset) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
            model_ov    = 1'b0;
            model_stall = 0;
            exp_q.delete();
        end else begin
            if (we && wr_addr != 5'd0) ref_rf[wr_addr] = wd;
            if (hz && model_stall < 65535) model_stall++;
            model_ov = acc ? 1'b1 : (out_ready ? 1'b0 : model_ov);
        end
        @(negedge clk);
    endtask

    // Monitor: whenever the DUT presents an instruction, compare it with the oldest
    // outstanding expectation, retiring it when downstream takes it.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b1 && out_valid === 1'b1) begin
                act = {op, func, ra, rb, rw, rda, rdb, extended};
                if (exp_q.size() == 0) begin
                    check("unexpected_out", act, 128'd0);
                end else begin
                    check("decode", act, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 0; instruction = 0; rb_selector = 0; ext_selector = 0;
        we = 0; wr_addr = 0; wd = 0; ex_load_valid = 0; ex_load_rd = 0; out_ready = 1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_ov = 0;
        model_stall = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        idle_inputs();
        reset = 0;
        @(negedge clk);
        in_valid = 1;
        instruction = mk(3'd1, 5'd1, 5'd1, 5'd1, 14'd5);
        repeat (2) cycle();
        check("reset_outs", {out_valid, op, func, ra, rb, rw, rda, rdb, extended, stall_count},
              128'd0);
        reset = 1;
        idle_inputs();

        // Write r5, then decode it.
        we = 1; wr_addr = 5; wd = 32'h1234;
        cycle();
        we = 0; in_valid = 1; instruction = mk(3'd3, 5'd2, 5'd5, 5'd0, 14'd0);
        cycle();
        in_valid = 0;
        cycle();

        // Same-cycle write-back bypass.
        in_valid = 1; instruction = mk(3'd2, 5'd1, 5'd7, 5'd7, 14'd1);
        we = 1; wr_addr = 7; wd = 32'hABCD;
        cycle();
        we = 0; in_valid = 0;
        cycle();

        // Immediate sign/zero extension.
        in_valid = 1; ext_selector = 2'b01; instruction = mk(3'd0, 5'd0, 5'd0, 5'd0, 14'h2000);
        cycle();
        check("ext_sign14", extended, 32'hFFFF_E000);
        ext_selector = 2'b00;
        cycle();
        check("ext_zero14", extended, 32'h0000_2000);
        in_valid = 0;
        cycle();

        // Load-use hazard on ra for two cycles, then release.
        in_valid = 1; instruction = mk(3'd4, 5'd3, 5'd4, 5'd1, 14'd2);
        ex_load_valid = 1; ex_load_rd = 4;
        repeat (2) cycle();
        check("stall_two", stall_count, 32'd2);
        ex_load_valid = 0;
        cycle();
        in_valid = 0;
        cycle();

        // Downstream backpressure; load to r0 never stalls.
        in_valid = 1; instruction = mk(3'd5, 5'd6, 5'd5, 5'd7, 14'h155);
        cycle();
        out_ready = 0; ex_load_valid = 1; ex_load_rd = 0;
        instruction = mk(3'd6, 5'd0, 5'd0, 5'd0, 14'h2A);
        repeat (3) cycle();
        check("no_stall_r0", stall_count, 32'd2);
        out_ready = 1;
        cycle();
        in_valid = 0; ex_load_valid = 0;
        cycle();

        // Reset while an instruction is held.
        in_valid = 1; instruction = mk(3'd7, 5'd1, 5'd2, 5'd3, 14'd9);
        cycle();
        out_ready = 0; in_valid = 0;
        cycle();
        reset = 0; in_valid = 1;
        cycle();
        reset = 1; in_valid = 0; out_ready = 1;
        check("mid_reset_outs", {out_valid, op, func, ra, rb, rw, rda, rdb, extended}, 128'd0);
        in_valid = 1; instruction = mk(3'd1, 5'd5, 5'd5, 5'd5, 14'd0);
        cycle();
        check("r5_cleared", rda, 32'd0);
        in_valid = 0;
        cycle();

        // Random traffic with small register indices so hazards and bypasses collide.
        for (int k = 0; k < 400; k++) begin
            in_valid      = ($urandom_range(0, 9) < 7);
            instruction   = $urandom;
            instruction[28:24] = 5'($urandom_range(0, 7));
            instruction[23:19] = 5'($urandom_range(0, 7));
            instruction[18:14] = 5'($urandom_range(0, 7));
            rb_selector   = 1'($urandom_range(0, 1));
            ext_selector  = 2'($urandom_range(0, 3));
            we            = ($urandom_range(0, 1) == 1);
            wr_addr       = 5'($urandom_range(0, 7));
            wd            = $urandom;
            ex_load_valid = ($urandom_range(0, 9) < 3);
            ex_load_rd    = 5'($urandom_range(0, 7));
            out_ready     = ($urandom_range(0, 9) < 7);
            cycle();
        end

        idle_inputs();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle();
        check("drain", exp_q.size(), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
